// File: rtl/ptp_lkup_ccm_tcam_if.sv
// ============================================================================
// Module   : ptp_lkup_ccm_tcam_if
// Brief    : Bundle of TCAM request/response, parser FIFO and egress signals
//            seen by the PTP bridge lookup stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ptp_lkup_ccm_tcam_if #(
    parameter int TDATA_WIDTH             = 512,
    parameter int TKEEP_WIDTH             = TDATA_WIDTH / 8,
    parameter int USERMETADATA_WIDTH      = 1,
    parameter int TCAM_KEY_WIDTH          = 64,
    parameter int TCAM_RESULT_WIDTH       = 2,
    parameter int TCAM_USERMETADATA_WIDTH = 1,
    parameter int CHTID_WIDTH             = 1,
    parameter int NUM_EGR_INTF            = 2
) ();
    localparam int SEG_W = $clog2(TKEEP_WIDTH) + 2;

    logic                                                 tcam_rsp_tvalid;
    logic [TCAM_RESULT_WIDTH-1:0]                         tcam_rsp_tuser_result;
    logic                                                 tcam_rsp_tuser_found;
    logic [TCAM_USERMETADATA_WIDTH-1:0]                   tcam_rsp_tuser_usermetadata;
    logic                                                 tcam_rsp_tready;

    logic                                                 tcam_req_tready;
    logic                                                 tcam_req_tvalid;
    logic [CHTID_WIDTH-1:0]                               tcam_req_tid;
    logic [TCAM_KEY_WIDTH-1:0]                            tcam_req_tuser_key;
    logic [TCAM_USERMETADATA_WIDTH-1:0]                   tcam_req_tuser_usermetadata;

    logic                                                 pars2lu_tvalid;
    logic [TDATA_WIDTH-1:0]                               pars2lu_tdata;
    logic [USERMETADATA_WIDTH-1:0]                        pars2lu_tuser_usermetadata;
    logic [SEG_W-1:0]                                     pars2lu_tuser_segment_info;
    logic [TCAM_KEY_WIDTH-1:0]                            pars2lu_tuser_lu_key;
    logic                                                 pars2lu_fifo_empty;
    logic                                                 lu2pars_fifo_rd;
    logic                                                 pars2lu_tcam_req_fifo_empty;
    logic                                                 lu2pars_tcam_req_fifo_rd;

    logic [NUM_EGR_INTF-1:0]                              lu2ewadj_tvalid;
    logic [NUM_EGR_INTF-1:0][TDATA_WIDTH-1:0]             lu2ewadj_tdata;
    logic [NUM_EGR_INTF-1:0][TKEEP_WIDTH-1:0]             lu2ewadj_tkeep;
    logic [NUM_EGR_INTF-1:0][USERMETADATA_WIDTH-1:0]      lu2ewadj_tuser_usermetadata;
    logic [NUM_EGR_INTF-1:0][SEG_W-1:0]                   lu2ewadj_tuser_segment_info;
    logic [NUM_EGR_INTF-1:0]                              ewadj2lu_tready;

    // Lookup stage side
    modport master (
        input  tcam_rsp_tvalid, tcam_rsp_tuser_result, tcam_rsp_tuser_found,
               tcam_rsp_tuser_usermetadata, tcam_req_tready,
               pars2lu_tvalid, pars2lu_tdata, pars2lu_tuser_usermetadata,
               pars2lu_tuser_segment_info, pars2lu_tuser_lu_key,
               pars2lu_fifo_empty, pars2lu_tcam_req_fifo_empty, ewadj2lu_tready,
        output tcam_rsp_tready, tcam_req_tvalid, tcam_req_tid, tcam_req_tuser_key,
               tcam_req_tuser_usermetadata, lu2pars_fifo_rd, lu2pars_tcam_req_fifo_rd,
               lu2ewadj_tvalid, lu2ewadj_tdata, lu2ewadj_tkeep,
               lu2ewadj_tuser_usermetadata, lu2ewadj_tuser_segment_info
    );

    // Surrounding pipeline side
    modport slave (
        output tcam_rsp_tvalid, tcam_rsp_tuser_result, tcam_rsp_tuser_found,
               tcam_rsp_tuser_usermetadata, tcam_req_tready,
               pars2lu_tvalid, pars2lu_tdata, pars2lu_tuser_usermetadata,
               pars2lu_tuser_segment_info, pars2lu_tuser_lu_key,
               pars2lu_fifo_empty, pars2lu_tcam_req_fifo_empty, ewadj2lu_tready,
        input  tcam_rsp_tready, tcam_req_tvalid, tcam_req_tid, tcam_req_tuser_key,
               tcam_req_tuser_usermetadata, lu2pars_fifo_rd, lu2pars_tcam_req_fifo_rd,
               lu2ewadj_tvalid, lu2ewadj_tdata, lu2ewadj_tkeep,
               lu2ewadj_tuser_usermetadata, lu2ewadj_tuser_segment_info
    );
endinterface

`default_nettype wire

// File: rtl/ptp_lkup_ccm_tcam.sv
// ============================================================================
// Module   : ptp_lkup_ccm_tcam
// Brief    : PTP RX lookup stage: issues TCAM lookups, pairs responses with
//            parsed packets in order and steers them to DMA/user or drops them.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ptp_lkup_ccm_tcam #(
    parameter int TDATA_WIDTH             = 512,
    parameter int TKEEP_WIDTH             = TDATA_WIDTH / 8,
    parameter int USERMETADATA_WIDTH      = 1,
    parameter int TCAM_KEY_WIDTH          = 64,
    parameter int TCAM_RESULT_WIDTH       = 2,
    parameter int TCAM_USERMETADATA_WIDTH = 1,
    parameter int CHTID_WIDTH             = 1,
    parameter int NUM_EGR_INTF            = 2,
    parameter int RSP_FIFO_DEPTH          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ptp_lkup_ccm_tcam_if.master  bus_io
);
    localparam int EMPTY_W = $clog2(TKEEP_WIDTH);
    localparam int SEG_W   = EMPTY_W + 2;
    localparam int RSP_W   = TCAM_RESULT_WIDTH + 1 + TCAM_USERMETADATA_WIDTH;
    localparam int PTR_W   = $clog2(RSP_FIFO_DEPTH);
    localparam int CRD_W   = PTR_W + 1;
    localparam int B_FOUND = TCAM_USERMETADATA_WIDTH;
    localparam int B_DROP  = TCAM_USERMETADATA_WIDTH + 1;
    localparam int B_EGR   = TCAM_USERMETADATA_WIDTH + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FWD  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    // ---------------- TCAM request issue with response credits ----------------
    logic                               req_valid_q;
    logic [TCAM_KEY_WIDTH-1:0]          req_key_q;
    logic [TCAM_USERMETADATA_WIDTH-1:0] req_umd_q;
    logic [CRD_W-1:0]                   credit_q;
    logic                               w_key_pop;
    logic                               w_rsp_pop;

    assign w_key_pop = !rst && !bus_io.pars2lu_tcam_req_fifo_empty &&
                       (!req_valid_q || bus_io.tcam_req_tready) &&
                       (credit_q < CRD_W'(RSP_FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_key_q   <= '0;
            req_umd_q   <= '0;
        end else if (w_key_pop) begin
            req_valid_q <= 1'b1;
            req_key_q   <= bus_io.pars2lu_tuser_lu_key;
            req_umd_q   <= bus_io.pars2lu_tuser_usermetadata[TCAM_USERMETADATA_WIDTH-1:0];
        end else if (bus_io.tcam_req_tready) begin
            req_valid_q <= 1'b0;
        end
    end

    // One credit per outstanding lookup keeps the response FIFO from overflowing
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= '0;
        end else if (w_key_pop && !w_rsp_pop) begin
            credit_q <= credit_q + CRD_W'(1);
        end else if (!w_key_pop && w_rsp_pop) begin
            credit_q <= credit_q - CRD_W'(1);
        end
    end

    assign bus_io.tcam_req_tvalid             = req_valid_q;
    assign bus_io.tcam_req_tuser_key          = req_key_q;
    assign bus_io.tcam_req_tuser_usermetadata = req_umd_q;
    assign bus_io.tcam_req_tid                = '0;
    assign bus_io.lu2pars_tcam_req_fifo_rd    = w_key_pop;

    // ---------------- Response FIFO ----------------
    logic [RSP_W-1:0] rsp_mem_q [RSP_FIFO_DEPTH];
    logic [PTR_W:0]   rsp_wr_q;
    logic [PTR_W:0]   rsp_rd_q;
    logic             w_rsp_full;
    logic             w_rsp_empty;
    logic             w_rsp_push;
    logic             w_rsp_found;
    logic             w_rsp_drop;
    logic             w_rsp_egr;

    assign w_rsp_empty = (rsp_wr_q == rsp_rd_q);
    assign w_rsp_full  = (rsp_wr_q[PTR_W] != rsp_rd_q[PTR_W]) &&
                         (rsp_wr_q[PTR_W-1:0] == rsp_rd_q[PTR_W-1:0]);
    assign w_rsp_push  = bus_io.tcam_rsp_tvalid && !w_rsp_full;
    assign bus_io.tcam_rsp_tready = !w_rsp_full;

    assign w_rsp_found = rsp_mem_q[rsp_rd_q[PTR_W-1:0]][B_FOUND];
    assign w_rsp_drop  = rsp_mem_q[rsp_rd_q[PTR_W-1:0]][B_DROP];
    assign w_rsp_egr   = rsp_mem_q[rsp_rd_q[PTR_W-1:0]][B_EGR];

    always_ff @(posedge clk) begin
        if (w_rsp_push) begin
            rsp_mem_q[rsp_wr_q[PTR_W-1:0]] <= {bus_io.tcam_rsp_tuser_result,
                                               bus_io.tcam_rsp_tuser_found,
                                               bus_io.tcam_rsp_tuser_usermetadata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_wr_q <= '0;
            rsp_rd_q <= '0;
        end else begin
            if (w_rsp_push) rsp_wr_q <= rsp_wr_q + (PTR_W+1)'(1);
            if (w_rsp_pop)  rsp_rd_q <= rsp_rd_q + (PTR_W+1)'(1);
        end
    end

    // ---------------- Packet steering FSM ----------------
    logic [1:0]               state_q, state_d;
    logic                     egr_q, egr_d;
    logic                     w_pkt_avail, w_sop, w_eop, w_egr_rdy;
    logic                     w_pkt_rd, w_fwd_load;
    logic [EMPTY_W-1:0]       w_empty;
    logic [TKEEP_WIDTH-1:0]   w_keep;

    assign w_pkt_avail = !bus_io.pars2lu_fifo_empty;
    assign w_sop       = bus_io.pars2lu_tuser_segment_info[SEG_W-1];
    assign w_eop       = bus_io.pars2lu_tuser_segment_info[SEG_W-2];
    assign w_empty     = bus_io.pars2lu_tuser_segment_info[EMPTY_W-1:0];
    assign w_keep      = w_eop ? ({TKEEP_WIDTH{1'b1}} >> w_empty) : {TKEEP_WIDTH{1'b1}};

    logic [NUM_EGR_INTF-1:0]                         out_valid_q;
    logic [NUM_EGR_INTF-1:0][TDATA_WIDTH-1:0]        out_data_q;
    logic [NUM_EGR_INTF-1:0][TKEEP_WIDTH-1:0]        out_keep_q;
    logic [NUM_EGR_INTF-1:0][USERMETADATA_WIDTH-1:0] out_umd_q;
    logic [NUM_EGR_INTF-1:0][SEG_W-1:0]              out_seg_q;

    assign w_egr_rdy = !out_valid_q[egr_q] || bus_io.ewadj2lu_tready[egr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            egr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            egr_q   <= egr_d;
        end
    end

    // A miss goes to the host (DMA) as an exception
    always_comb begin
        state_d = state_q;
        egr_d   = egr_q;
        case (state_q)
            S_IDLE: begin
                if (w_pkt_avail && w_sop && !w_rsp_empty) begin
                    if (w_rsp_found && w_rsp_drop) begin
                        state_d = S_DROP;
                    end else begin
                        state_d = S_FWD;
                        egr_d   = w_rsp_found ? w_rsp_egr : 1'b0;
                    end
                end
            end
            S_FWD:   if (w_pkt_avail && w_egr_rdy && w_eop) state_d = S_IDLE;
            S_DROP:  if (w_pkt_avail && w_eop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_pkt_rd   = 1'b0;
        w_rsp_pop  = 1'b0;
        w_fwd_load = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (w_pkt_avail && !w_sop) begin
                        w_pkt_rd = 1'b1;
                    end else if (w_pkt_avail && !w_rsp_empty) begin
                        w_rsp_pop = 1'b1;
                    end
                end
                S_FWD: begin
                    w_pkt_rd   = w_pkt_avail && w_egr_rdy;
                    w_fwd_load = w_pkt_avail && w_egr_rdy;
                end
                S_DROP:  w_pkt_rd = w_pkt_avail;
                default: w_pkt_rd = 1'b0;
            endcase
        end
    end

    assign bus_io.lu2pars_fifo_rd = w_pkt_rd;

    // ---------------- Egress AXI-S registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_umd_q   <= '0;
            out_seg_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_EGR_INTF; i++) begin
                if (w_fwd_load && (int'(egr_q) == i)) begin
                    out_valid_q[i] <= 1'b1;
                    out_data_q[i]  <= bus_io.pars2lu_tdata;
                    out_keep_q[i]  <= w_keep;
                    out_umd_q[i]   <= bus_io.pars2lu_tuser_usermetadata;
                    out_seg_q[i]   <= bus_io.pars2lu_tuser_segment_info;
                end else if (bus_io.ewadj2lu_tready[i]) begin
                    out_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus_io.lu2ewadj_tvalid             = out_valid_q;
    assign bus_io.lu2ewadj_tdata              = out_data_q;
    assign bus_io.lu2ewadj_tkeep              = out_keep_q;
    assign bus_io.lu2ewadj_tuser_usermetadata = out_umd_q;
    assign bus_io.lu2ewadj_tuser_segment_info = out_seg_q;

endmodule

`default_nettype wire

// File: tb/tb_ptp_lkup_ccm_tcam.sv
// ============================================================================
// Module   : tb_ptp_lkup_ccm_tcam
// Brief    : Directed self-checking bench for the PTP lookup stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ptp_lkup_ccm_tcam;
    localparam int TDW   = 64;
    localparam int KW    = 16;
    localparam int SEG_W = 5;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        umd;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ptp_lkup_ccm_tcam_if #(.TDATA_WIDTH(TDW), .TCAM_KEY_WIDTH(KW)) bus ();

    ptp_lkup_ccm_tcam #(.TDATA_WIDTH(TDW), .TCAM_KEY_WIDTH(KW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.master)
    );

    int checks = 0;
    int errors = 0;
    word_t          pkt_q[$];
    logic [KW-1:0]  key_q[$];
    logic [KW-1:0]  req_log[$];
    logic [72:0]    cap0[$];
    logic [72:0]    cap1[$];
    int pkt_pops = 0;
    int key_pops = 0;
    logic [1:0]     stall_prev = 2'b00;
    logic [63:0]    prev_data [2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push_key(input logic [KW-1:0] k);
        key_q.push_back(k);
    endtask

    task automatic push_pkt(input int n, input logic [63:0] base, input logic [2:0] empty);
        for (int w = 0; w < n; w++) begin
            word_t x;
            x.data  = base + 64'(w);
            x.sop   = (w == 0);
            x.eop   = (w == n - 1);
            x.empty = (w == n - 1) ? empty : 3'd0;
            x.umd   = 1'(w);
            pkt_q.push_back(x);
        end
    endtask

    task automatic send_rsp(input logic found, input logic egr, input logic drop);
        bus.tcam_rsp_tvalid       = 1'b1;
        bus.tcam_rsp_tuser_found  = found;
        bus.tcam_rsp_tuser_result = {egr, drop};
        cyc();
        bus.tcam_rsp_tvalid       = 1'b0;
    endtask

    task automatic wait_cap(input int intf, input int n, input int budget);
        int k = 0;
        while (((intf == 0) ? cap0.size() : cap1.size()) < n && k < budget) begin
            cyc();
            k++;
        end
        chk($sformatf("beat_timeout_intf%0d", intf),
            128'(((intf == 0) ? cap0.size() : cap1.size()) >= n), 128'(1));
    endtask

    // Show-ahead parser FIFOs: pop on the edge that saw rd, then present the new head
    always begin
        logic pk, kk;
        word_t tmp_w;
        logic [KW-1:0] tmp_k;
        @(negedge clk);
        pk = bus.lu2pars_fifo_rd;
        kk = bus.lu2pars_tcam_req_fifo_rd;
        @(posedge clk);
        #1;
        if (pk && pkt_q.size() > 0) tmp_w = pkt_q.pop_front();
        if (kk && key_q.size() > 0) tmp_k = key_q.pop_front();
        bus.pars2lu_fifo_empty = (pkt_q.size() == 0);
        bus.pars2lu_tvalid     = (pkt_q.size() != 0);
        if (pkt_q.size() != 0) begin
            bus.pars2lu_tdata              = pkt_q[0].data;
            bus.pars2lu_tuser_segment_info = {pkt_q[0].sop, pkt_q[0].eop, pkt_q[0].empty};
            bus.pars2lu_tuser_usermetadata = pkt_q[0].umd;
        end else begin
            bus.pars2lu_tdata              = '0;
            bus.pars2lu_tuser_segment_info = '0;
            bus.pars2lu_tuser_usermetadata = '0;
        end
        bus.pars2lu_tcam_req_fifo_empty = (key_q.size() == 0);
        bus.pars2lu_tuser_lu_key        = (key_q.size() != 0) ? key_q[0] : '0;
    end

    // Bus monitor: pops, issued requests, accepted beats, stall stability
    always @(negedge clk) begin
        if (bus.lu2pars_fifo_rd === 1'b1) begin
            pkt_pops++;
            chk("pkt_rd_while_empty", 128'(pkt_q.size() != 0), 128'(1));
        end
        if (bus.lu2pars_tcam_req_fifo_rd === 1'b1) begin
            key_pops++;
            chk("key_rd_while_empty", 128'(key_q.size() != 0), 128'(1));
        end
        if (bus.tcam_req_tvalid === 1'b1 && bus.tcam_req_tready === 1'b1)
            req_log.push_back(bus.tcam_req_tuser_key);
        for (int i = 0; i < 2; i++) begin
            if (!rst && stall_prev[i])
                chk($sformatf("stall_stable_intf%0d", i),
                    {63'd0, bus.lu2ewadj_tvalid[i], bus.lu2ewadj_tdata[i]},
                    {63'd0, 1'b1, prev_data[i]});
            if (bus.lu2ewadj_tvalid[i] === 1'b1 && bus.ewadj2lu_tready[i]) begin
                if (i == 0) cap0.push_back({bus.lu2ewadj_tuser_segment_info[0][3],
                                            bus.lu2ewadj_tkeep[0], bus.lu2ewadj_tdata[0]});
                else        cap1.push_back({bus.lu2ewadj_tuser_segment_info[1][3],
                                            bus.lu2ewadj_tkeep[1], bus.lu2ewadj_tdata[1]});
            end
            stall_prev[i] = !rst && (bus.lu2ewadj_tvalid[i] === 1'b1) && !bus.ewadj2lu_tready[i];
            prev_data[i]  = bus.lu2ewadj_tdata[i];
        end
    end

    initial begin
        int kb, lb, pb, c0b, k;
        rst = 1'b1;
        bus.tcam_rsp_tvalid = 1'b0;
        bus.tcam_rsp_tuser_result = '0;
        bus.tcam_rsp_tuser_found = 1'b0;
        bus.tcam_rsp_tuser_usermetadata = '0;
        bus.tcam_req_tready = 1'b1;
        bus.ewadj2lu_tready = 2'b11;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_tvalid",   128'(bus.lu2ewadj_tvalid), 128'(0));
        chk("rst_pkt_rd",   128'(bus.lu2pars_fifo_rd), 128'(0));
        chk("rst_key_rd",   128'(bus.lu2pars_tcam_req_fifo_rd), 128'(0));
        chk("rst_req_vld",  128'(bus.tcam_req_tvalid), 128'(0));
        chk("rst_rsp_rdy",  128'(bus.tcam_rsp_tready), 128'(1));
        cyc();
        rst = 1'b0;

        // Hit to user egress, 3 words, 2 empty bytes on last
        push_key(16'h1111);
        push_pkt(3, 64'hA0, 3'd2);
        repeat (3) cyc();
        chk("t1_req_key",   128'(req_log.size() == 1 ? req_log[0] : 16'h0), 128'(16'h1111));
        chk("t1_req_tid",   128'(bus.tcam_req_tid), 128'(0));
        send_rsp(1'b1, 1'b1, 1'b0);
        wait_cap(1, 3, 20);
        repeat (2) cyc();
        chk("t1_cnt1",      128'(cap1.size()), 128'(3));
        chk("t1_cnt0",      128'(cap0.size()), 128'(0));
        chk("t1_beat0",     128'(cap1[0]), {55'd0, 1'b0, 8'hFF, 64'hA0});
        chk("t1_beat1",     128'(cap1[1]), {55'd0, 1'b0, 8'hFF, 64'hA1});
        chk("t1_beat2",     128'(cap1[2]), {55'd0, 1'b1, 8'h3F, 64'hA2});

        // Miss goes to DMA even with egr_port=1
        push_key(16'h2222);
        push_pkt(1, 64'hB0, 3'd0);
        repeat (3) cyc();
        send_rsp(1'b0, 1'b1, 1'b1);
        wait_cap(0, 1, 20);
        chk("t2_beat",      128'(cap0[0]), {55'd0, 1'b1, 8'hFF, 64'hB0});
        chk("t2_cnt1",      128'(cap1.size()), 128'(3));

        // Dropped 4-word packet followed by a good one
        pb = pkt_pops;
        push_key(16'h3333);
        push_pkt(4, 64'hC0, 3'd5);
        push_key(16'h4444);
        push_pkt(1, 64'hD0, 3'd0);
        repeat (3) cyc();
        send_rsp(1'b1, 1'b0, 1'b1);
        send_rsp(1'b1, 1'b0, 1'b0);
        wait_cap(0, 2, 30);
        repeat (2) cyc();
        chk("t3_beat",      128'(cap0[1]), {55'd0, 1'b1, 8'hFF, 64'hD0});
        chk("t3_cnt0",      128'(cap0.size()), 128'(2));
        chk("t3_cnt1",      128'(cap1.size()), 128'(3));
        chk("t3_pops",      128'(pkt_pops - pb), 128'(5));

        // Request backpressure: first key held, no further pops
        bus.tcam_req_tready = 1'b0;
        kb = key_pops;
        lb = req_log.size();
        push_key(16'h5555);
        push_key(16'h6666);
        push_key(16'h7777);
        repeat (10) cyc();
        @(negedge clk);
        chk("t4_hold_vld",  128'(bus.tcam_req_tvalid), 128'(1));
        chk("t4_hold_key",  128'(bus.tcam_req_tuser_key), 128'(16'h5555));
        chk("t4_hold_pops", 128'(key_pops - kb), 128'(1));
        chk("t4_hold_log",  128'(req_log.size() - lb), 128'(0));
        cyc();
        bus.tcam_req_tready = 1'b1;
        repeat (6) cyc();
        chk("t4_rel_log",   128'(req_log.size() - lb), 128'(3));
        chk("t4_rel_k0",    128'(req_log[lb]),     128'(16'h5555));
        chk("t4_rel_k1",    128'(req_log[lb + 1]), 128'(16'h6666));
        chk("t4_rel_k2",    128'(req_log[lb + 2]), 128'(16'h7777));
        pb = pkt_pops;
        push_pkt(1, 64'hE0, 3'd0);
        push_pkt(1, 64'hE1, 3'd0);
        push_pkt(1, 64'hE2, 3'd0);
        send_rsp(1'b1, 1'b0, 1'b1);
        send_rsp(1'b1, 1'b0, 1'b1);
        send_rsp(1'b1, 1'b0, 1'b1);
        repeat (12) cyc();
        chk("t4_drain",     128'(pkt_pops - pb), 128'(3));

        // DMA packet with toggling egress ready
        c0b = cap0.size();
        push_key(16'h8888);
        push_pkt(5, 64'hF0, 3'd0);
        repeat (3) cyc();
        send_rsp(1'b0, 1'b0, 1'b0);
        k = 0;
        while (cap0.size() < c0b + 5 && k < 40) begin
            bus.ewadj2lu_tready[0] = ~bus.ewadj2lu_tready[0];
            cyc();
            k++;
        end
        bus.ewadj2lu_tready = 2'b11;
        repeat (3) cyc();
        chk("t6_cnt",       128'(cap0.size() - c0b), 128'(5));
        for (int w = 0; w < 5; w++)
            chk($sformatf("t6_beat%0d", w), 128'(cap0[c0b + w]),
                {55'd0, (w == 4), 8'hFF, 64'hF0 + 64'(w)});

        // Credit limit: 20 keys, no responses
        kb = key_pops;
        lb = req_log.size();
        for (int i = 0; i < 20; i++) push_key(16'h9000 + 16'(i));
        repeat (40) cyc();
        @(negedge clk);
        chk("t5_pops",      128'(key_pops - kb), 128'(16));
        chk("t5_issued",    128'(req_log.size() - lb), 128'(16));
        chk("t5_stall_rd",  128'(bus.lu2pars_tcam_req_fifo_rd), 128'(0));
        cyc();
        push_pkt(1, 64'h60, 3'd0);
        send_rsp(1'b1, 1'b0, 1'b1);
        k = 0;
        while (req_log.size() < lb + 17 && k < 20) begin
            cyc();
            k++;
        end
        chk("t5_resume",    128'(req_log.size() - lb), 128'(17));
        chk("t5_key17",     128'(req_log[lb + 16]), 128'(16'h9010));

        // Reset in the middle of a stalled forward
        push_pkt(4, 64'h70, 3'd0);
        bus.ewadj2lu_tready = 2'b01;
        send_rsp(1'b1, 1'b1, 1'b0);
        k = 0;
        while (bus.lu2ewadj_tvalid[1] !== 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        chk("t7_fwd_vld",   128'(bus.lu2ewadj_tvalid[1]), 128'(1));
        rst = 1'b1;
        pkt_q.delete();
        key_q.delete();
        cyc();
        @(negedge clk);
        chk("t7_rst_vld",   128'(bus.lu2ewadj_tvalid), 128'(0));
        chk("t7_rst_rd",    128'(bus.lu2pars_fifo_rd), 128'(0));
        chk("t7_rst_krd",   128'(bus.lu2pars_tcam_req_fifo_rd), 128'(0));
        cyc();
        rst = 1'b0;
        bus.ewadj2lu_tready = 2'b11;
        c0b = cap0.size();
        push_key(16'hAAAA);
        push_pkt(2, 64'h80, 3'd3);
        repeat (3) cyc();
        chk("t7_req_key",   128'(req_log[$]), 128'(16'hAAAA));
        send_rsp(1'b1, 1'b0, 1'b0);
        wait_cap(0, c0b + 2, 20);
        chk("t7_beat0",     128'(cap0[c0b]),     {55'd0, 1'b0, 8'hFF, 64'h80});
        chk("t7_beat1",     128'(cap0[c0b + 1]), {55'd0, 1'b1, 8'h1F, 64'h81});
        chk("t7_cnt1",      128'(cap1.size()), 128'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
